// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU input path: data/address widths and the
// input setup sequencer state encoding.
package tpu_pkg;

   localparam int DATA_W     = 8;
   localparam int ADDR_W     = 13;
   localparam int TILE_WORDS = 4;
   localparam int CNT_W      = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_CAP,
      ST_SKEW0,
      ST_SKEW1,
      ST_SKEW2,
      ST_DONE
   } seq_state_t;

endpackage

// File: rtl/input_setup_sequencer.sv
// Fetches 2x2 input tiles from the unified buffer and feeds them into the two
// systolic rows as a three-beat diagonal skew, honouring sa_ready backpressure.
module input_setup_sequencer
   import tpu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  tile_count,
   output logic              ub_load_input,
   output logic [ADDR_W-1:0] ub_addr,
   input  logic [DATA_W-1:0] ub_00,
   input  logic [DATA_W-1:0] ub_01,
   input  logic [DATA_W-1:0] ub_10,
   input  logic [DATA_W-1:0] ub_11,
   input  logic              sa_ready,
   output logic [DATA_W-1:0] sa_in_0,
   output logic [DATA_W-1:0] sa_in_1,
   output logic              sa_valid_0,
   output logic              sa_valid_1,
   output logic              busy,
   output logic              done
);

   seq_state_t        state, state_next;
   logic [ADDR_W-1:0] addr_ptr;
   logic [CNT_W-1:0]  tiles_left;
   logic [DATA_W-1:0] a00, a01, a10, a11;
   logic              load_params, capture, tile_step;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // All outputs decode from registered state and tile registers only.
   always_comb begin
      state_next    = state;
      ub_load_input = 1'b0;
      ub_addr       = '0;
      sa_in_0       = '0;
      sa_in_1       = '0;
      sa_valid_0    = 1'b0;
      sa_valid_1    = 1'b0;
      busy          = (state != ST_IDLE);
      done          = 1'b0;
      load_params   = 1'b0;
      capture       = 1'b0;
      tile_step     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (tile_count != '0) begin
                  load_params = 1'b1;
                  state_next  = ST_REQ;
               end else begin
                  state_next  = ST_DONE;
               end
            end
         end
         ST_REQ: begin
            ub_load_input = 1'b1;
            ub_addr       = addr_ptr;
            state_next    = ST_CAP;
         end
         ST_CAP: begin
            capture    = 1'b1;
            state_next = ST_SKEW0;
         end
         ST_SKEW0: begin
            sa_in_0    = a00;
            sa_valid_0 = 1'b1;
            if (sa_ready) state_next = ST_SKEW1;
         end
         ST_SKEW1: begin
            sa_in_0    = a01;
            sa_in_1    = a10;
            sa_valid_0 = 1'b1;
            sa_valid_1 = 1'b1;
            if (sa_ready) state_next = ST_SKEW2;
         end
         ST_SKEW2: begin
            sa_in_1    = a11;
            sa_valid_1 = 1'b1;
            if (sa_ready) begin
               tile_step  = 1'b1;
               // tiles_left is at least 1 here, so the decrement hits zero only from 1.
               state_next = (tiles_left == CNT_W'(1)) ? ST_DONE : ST_REQ;
            end
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_ptr   <= '0;
         tiles_left <= '0;
      end else if (load_params) begin
         addr_ptr   <= base_addr;
         tiles_left <= tile_count;
      end else if (tile_step) begin
         // Address wraps modulo the buffer size by design.
         addr_ptr   <= addr_ptr + ADDR_W'(TILE_WORDS);
         tiles_left <= tiles_left - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a00 <= '0;
         a01 <= '0;
         a10 <= '0;
         a11 <= '0;
      end else if (capture) begin
         a00 <= ub_00;
         a01 <= ub_01;
         a10 <= ub_10;
         a11 <= ub_11;
      end
   end

endmodule

// File: tb/tb_input_setup_sequencer.sv
// Scoreboard bench for input_setup_sequencer: stimulus queues expected reads,
// skew beats and done cycles; a negedge monitor pops and compares them.
module tb_input_setup_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [12:0] base_addr;
   logic [5:0]  tile_count;
   logic        ub_load_input;
   logic [12:0] ub_addr;
   logic [7:0]  ub_00, ub_01, ub_10, ub_11;
   logic        sa_ready;
   logic [7:0]  sa_in_0, sa_in_1;
   logic        sa_valid_0, sa_valid_1;
   logic        busy, done;

   logic [7:0]  mem [0:8191];
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;

   logic [12:0] exp_rd   [$];
   logic [17:0] exp_beat [$];   // {valid_0, valid_1, sa_in_0, sa_in_1}
   int          exp_done [$];

   input_setup_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .tile_count(tile_count), .ub_load_input(ub_load_input), .ub_addr(ub_addr),
      .ub_00(ub_00), .ub_01(ub_01), .ub_10(ub_10), .ub_11(ub_11),
      .sa_ready(sa_ready), .sa_in_0(sa_in_0), .sa_in_1(sa_in_1),
      .sa_valid_0(sa_valid_0), .sa_valid_1(sa_valid_1), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Unified buffer model: data registered one cycle after the strobe.
   always @(posedge clk) begin
      if (ub_load_input) begin
         ub_00 <= mem[ub_addr];
         ub_01 <= mem[13'(ub_addr + 13'd1)];
         ub_10 <= mem[13'(ub_addr + 13'd2)];
         ub_11 <= mem[13'(ub_addr + 13'd3)];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares every DUT event against the scoreboard queues.
   always @(negedge clk) begin
      logic [17:0] got_beat;
      if (!reset) begin
         if (ub_load_input) begin
            if (exp_rd.size() == 0) chk("unexpected_read", 32'(ub_addr), 32'hFFFF_FFFF);
            else                    chk("read_addr", 32'(ub_addr), 32'(exp_rd.pop_front()));
         end
         if (sa_valid_0 || sa_valid_1) begin
            got_beat = {sa_valid_0, sa_valid_1, sa_in_0, sa_in_1};
            if (exp_beat.size() == 0) chk("unexpected_beat", 32'(got_beat), 32'hFFFF_FFFF);
            else                      chk("skew_beat", 32'(got_beat), 32'(exp_beat.pop_front()));
         end
         if (done) begin
            chk("busy_in_done", 32'(busy), 32'd1);
            if (exp_done.size() == 0) chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
            else                      chk("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
         end
      end
   end

   task automatic push_tile(input logic [7:0] x00, input logic [7:0] x01,
                            input logic [7:0] x10, input logic [7:0] x11);
      exp_beat.push_back({2'b10, x00, 8'h00});
      exp_beat.push_back({2'b11, x01, x10});
      exp_beat.push_back({2'b01, 8'h00, x11});
   endtask

   // Issues start at a negedge; k is the cycle index of the first post-start cycle.
   task automatic issue(input logic [12:0] b, input logic [5:0] n, input int done_off,
                        output int k);
      @(negedge clk);
      k = cyc + 1;
      if (done_off >= 0) exp_done.push_back(k + done_off);
      base_addr  = b;
      tile_count = n;
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_cyc(input int t);
      int guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (cyc < t && guard < 200);
      if (guard >= 200) chk("wait_cycle_timeout", 32'(cyc), 32'(t));
   endtask

   task automatic wait_idle();
      int guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (busy && guard < 300);
      if (guard >= 300) chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},  32'(busy), 32'd0);
      chk({tag, "_done"},  32'(done), 32'd0);
      chk({tag, "_load"},  32'(ub_load_input), 32'd0);
      chk({tag, "_addr"},  32'(ub_addr), 32'd0);
      chk({tag, "_sa"},    32'({sa_valid_0, sa_valid_1, sa_in_0, sa_in_1}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      reset = 1'b1; start = 1'b0; base_addr = '0; tile_count = '0; sa_ready = 1'b1;
      for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
      mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd4;
      for (int t = 0; t < 3; t++)
         for (int j = 0; j < 4; j++) mem[8 + 4*t + j] = 8'(16*(t + 1) + j + 1);
      mem[8188] = 8'hA1; mem[8189] = 8'hA2; mem[8190] = 8'hA3; mem[8191] = 8'hA4;

      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b0;

      // Single tile at address 0
      exp_rd.push_back(13'd0);
      push_tile(8'd1, 8'd2, 8'd3, 8'd4);
      issue(13'd0, 6'd1, 5, k);
      wait_idle();

      // Three tiles from address 8, busy held throughout
      exp_rd.push_back(13'd8); exp_rd.push_back(13'd12); exp_rd.push_back(13'd16);
      push_tile(8'h11, 8'h12, 8'h13, 8'h14);
      push_tile(8'h21, 8'h22, 8'h23, 8'h24);
      push_tile(8'h31, 8'h32, 8'h33, 8'h34);
      issue(13'd8, 6'd3, 15, k);
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         chk("busy_multi", 32'(busy), 32'd1);
      end
      wait_idle();

      // Three-cycle stall in SKEW1
      exp_rd.push_back(13'd0);
      exp_beat.push_back({2'b10, 8'd1, 8'd0});
      repeat (4) exp_beat.push_back({2'b11, 8'd2, 8'd3});
      exp_beat.push_back({2'b01, 8'd0, 8'd4});
      issue(13'd0, 6'd1, 8, k);
      wait_cyc(k + 3);
      sa_ready = 1'b0;
      wait_cyc(k + 6);
      sa_ready = 1'b1;
      wait_idle();

      // Zero count: immediate done, no read
      issue(13'd40, 6'd0, 0, k);
      wait_idle();

      // Start while busy is ignored
      exp_rd.push_back(13'd8);
      push_tile(8'h11, 8'h12, 8'h13, 8'h14);
      issue(13'd8, 6'd1, 5, k);
      wait_cyc(k + 2);
      base_addr = 13'd100; tile_count = 6'd5; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle();

      // Address wrap-around
      exp_rd.push_back(13'd8188); exp_rd.push_back(13'd0);
      push_tile(8'hA1, 8'hA2, 8'hA3, 8'hA4);
      push_tile(8'd1, 8'd2, 8'd3, 8'd4);
      issue(13'd8188, 6'd2, 10, k);
      wait_idle();

      // Asynchronous reset during SKEW1, then a clean run
      exp_rd.push_back(13'd0);
      exp_beat.push_back({2'b10, 8'd1, 8'd0});
      exp_beat.push_back({2'b11, 8'd2, 8'd3});
      issue(13'd0, 6'd1, -1, k);
      wait_cyc(k + 3);
      #2 reset = 1'b1;
      #1 chk_all_zero("midrun_reset");
      @(negedge clk);
      chk_all_zero("reset_held");
      reset = 1'b0;
      exp_rd.push_back(13'd0);
      push_tile(8'd1, 8'd2, 8'd3, 8'd4);
      issue(13'd0, 6'd1, 5, k);
      wait_idle();

      repeat (5) @(negedge clk);
      chk("reads_left", 32'(exp_rd.size()), 32'd0);
      chk("beats_left", 32'(exp_beat.size()), 32'd0);
      chk("dones_left", 32'(exp_done.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/input_setup_sequencer.md
INPUT_SETUP_SEQUENCER -- requirements
Module: input_setup_sequencer

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-high; clears all state.
REQ-003 start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-004 base_addr  input  13  unified-buffer address of the first 2x2 tile; sampled with start.
REQ-005 tile_count  input  6  number of tiles in the run; sampled with start.
REQ-006 ub_load_input  output  1  read strobe to the unified buffer.
REQ-007 ub_addr  output  13  unified-buffer read address.
REQ-008 ub_00, ub_01, ub_10, ub_11  input  8 each  unified-buffer read data, registered one cycle after the strobe.
REQ-009 sa_ready  input  1  systolic array accepts the current skew beat.
REQ-010 sa_in_0, sa_in_1  output  8 each  row-0 and row-1 systolic inputs.
REQ-011 sa_valid_0, sa_valid_1  output  1 each  per-row valid.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when a run completes.

Function
REQ-014 FSM states: IDLE, REQ, CAP, SKEW0, SKEW1, SKEW2, DONE.
REQ-015 IDLE: start=1 with tile_count>0 latches base_addr into addr_ptr and tile_count into tiles_left, then goes to REQ.
REQ-016 IDLE: start=1 with tile_count=0 goes directly to DONE; no read is issued.
REQ-017 REQ (one cycle): ub_load_input=1 and ub_addr=addr_ptr; go to CAP.
REQ-018 CAP (one cycle): latch ub_00..ub_11 into tile registers a00, a01, a10, a11; go to SKEW0.
REQ-019 SKEW0: sa_in_0=a00, sa_valid_0=1; sa_in_1=0, sa_valid_1=0.
REQ-020 SKEW1: sa_in_0=a01, sa_in_1=a10; both valids 1.
REQ-021 SKEW2: sa_in_0=0, sa_valid_0=0; sa_in_1=a11, sa_valid_1=1.
REQ-022 A skew beat advances only on a rising edge with sa_ready=1; otherwise state, outputs and tile registers hold.
REQ-023 SKEW2 accepted: decrement tiles_left and add 4 to addr_ptr, mod 2^13 (wrap-around permitted).
REQ-024 After SKEW2 is accepted, go to REQ if the decremented tiles_left is nonzero, otherwise go to DONE.
REQ-025 DONE (one cycle): done=1, busy=1; go to IDLE.
REQ-026 Unstalled latency: start at edge T gives REQ in cycle T+1, SKEW0..SKEW2 in T+3..T+5 and done in the cycle after the last SKEW2; each tile takes 5 cycles.
REQ-027 start while busy is ignored and does not change latched parameters.
REQ-028 In all non-SKEW states: sa_in_*=0, sa_valid_*=0. ub_load_input=0 in every state except REQ.
REQ-029 Outputs are decoded combinationally from registered state and tile registers only; no input-to-output combinational path except through registers.
REQ-030 sa_ready is ignored outside the SKEW states; no stall is possible in REQ or CAP.

Reset
REQ-031 Asserting reset at any time, including mid-run, forces IDLE immediately.
REQ-032 Reset clears addr_ptr, tiles_left and tile registers, and drives ub_load_input, ub_addr, sa_in_*, sa_valid_*, busy and done to 0.
REQ-033 After reset deasserts, the first start is honoured on the next rising edge.

Structure
REQ-034 A shared package tpu_pkg holds the state enum, DATA_W=8, ADDR_W=13 and TILE_WORDS=4.
REQ-035 The block is a single module with no sub-modules; the FSM, address/tile counters and skew muxing live together.

Verification
REQ-036 Single tile: base=0, count=1, memory 0..3 = 1,2,3,4, sa_ready=1 -> addr 0 strobed once; (sa_in_0, sa_in_1) over SKEW0..2 = (1,0), (2,3), (0,4) with valids 10, 11, 01; done pulse 5 cycles after REQ.
REQ-037 Multi-tile: base=8, count=3 -> reads at 8, 12, 16; 15 cycles from first REQ to done; busy high continuously.
REQ-038 Stall: sa_ready=0 for 3 cycles during SKEW1 -> (2,3) with valids 11 held 4 cycles; remaining sequence and done delayed by exactly 3 cycles.
REQ-039 Zero count and busy start: count=0 -> done in the cycle after start, no ub_load_input; a second start during a run -> ignored, read addresses unchanged.
REQ-040 Wrap and reset: base=8188, count=2 -> reads at 8188, then 0. Reset asserted in SKEW1 -> all outputs 0 immediately, IDLE; a new run then completes normally.
